alu_mdu: RTL

Parametrised execute unit for the pipelined RISC-V core: a registered ALU for single-cycle integer operations plus an iterative unsigned multiplier and divider behind a valid/ready handshake. It takes an encoded opcode instead of one-hot enables, adds shifts, compares, MUL/MULHU/DIVU/REMU and a tag passthrough, and sits in the EX stage. The pipeline stalls on `in_ready` while a multi-cycle op is in flight.

---
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// EX-stage execute unit: registered single-cycle ALU plus iterative unsigned
// multiplier/divider, valid/ready on both sides, tag carried with each op.
module alu_mdu #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic [2*WIDTH-1:0]     acc_q, acc_n;
    logic [WIDTH-1:0]       opnd_q, opnd_n;
    logic                   sel_hi_q, sel_hi_n;
    logic                   out_valid_n;
    logic [WIDTH-1:0]       out_data_n;
    logic [TAG_WIDTH-1:0]   out_tag_n;

    logic                   accept;
    logic                   is_mul;
    logic                   is_div;
    logic [WIDTH-1:0]       alu_res;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_acc;
    logic [WIDTH:0]         div_trial;
    logic [2*WIDTH-1:0]     div_acc;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready) && !reset;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (in_op == OP_MUL) || (in_op == OP_MULHU);
    assign is_div   = ((in_op == OP_DIVU) || (in_op == OP_REMU)) && (in_b != '0);

    // Single-cycle result; divide-by-zero is resolved here too.
    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_SLL:  alu_res = in_a << in_b[SH_W-1:0];
            OP_SRL:  alu_res = in_a >> in_b[SH_W-1:0];
            OP_SRA:  alu_res = $unsigned($signed(in_a) >>> in_b[SH_W-1:0]);
            OP_SLT:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
            OP_SLTU: alu_res = WIDTH'(in_a < in_b);
            OP_DIVU: alu_res = '1;
            OP_REMU: alu_res = in_a;
            default: alu_res = '0;
        endcase
    end

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (div_trial[WIDTH]) begin
            div_acc = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            div_acc = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        acc_n       = acc_q;
        opnd_n      = opnd_q;
        sel_hi_n    = sel_hi_q;
        out_valid_n = out_valid && !out_ready;
        out_data_n  = out_data;
        out_tag_n   = out_tag;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_tag_n = in_tag;
                    sel_hi_n  = (in_op == OP_MULHU) || (in_op == OP_REMU);
                    cnt_n     = '0;
                    if (is_mul) begin
                        state_n = MUL_BUSY;
                        acc_n   = {{WIDTH{1'b0}}, in_b};
                        opnd_n  = in_a;
                    end else if (is_div) begin
                        state_n = DIV_BUSY;
                        acc_n   = {{WIDTH{1'b0}}, in_a};
                        opnd_n  = in_b;
                    end else begin
                        out_valid_n = 1'b1;
                        out_data_n  = alu_res;
                    end
                end
            end
            MUL_BUSY: begin
                acc_n = mul_acc;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = sel_hi_q ? mul_acc[2*WIDTH-1:WIDTH] : mul_acc[WIDTH-1:0];
                end
            end
            DIV_BUSY: begin
                acc_n = div_acc;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = sel_hi_q ? div_acc[2*WIDTH-1:WIDTH] : div_acc[WIDTH-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            sel_hi_q  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            acc_q     <= acc_n;
            opnd_q    <= opnd_n;
            sel_hi_q  <= sel_hi_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_tag   <= out_tag_n;
        end
    end

endmodule
